// File: rtl/viterbi_ctrl_pkg.sv
// Shared types and constants for the Viterbi link controller.
// Error injection is enabled by defining VITERBI_ERR_INJ_EN.
package viterbi_ctrl_pkg;

  localparam int unsigned SYM_W    = 2;
  localparam int unsigned ERR_CT_W = 16;
  localparam logic [SYM_W-1:0] INJ_MASK = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StTail,
    StDrain,
    StDone
  } ctrl_state_t;

endpackage

// File: rtl/viterbi_err_inj.sv
// Registered encoder-to-decoder symbol path with periodic single-bit error injection.
// Injection and error counting exist only when VITERBI_ERR_INJ_EN is defined.
module viterbi_err_inj
  import viterbi_ctrl_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned ERR_WINDOW = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start_i,
  input  logic                enc_valid_i,
  input  logic [SYM_W-1:0]    enc_sym_i,
  output logic                dec_en_o,
  output logic [SYM_W-1:0]    dec_sym_o,
  output logic [ERR_CT_W-1:0] err_ct_o
);

  logic [SYM_W-1:0] mask;

`ifdef VITERBI_ERR_INJ_EN
  // Wide enough to hold ERR_WINDOW itself and to expose the low N index bits.
  localparam int unsigned CtW0    = $clog2(ERR_WINDOW + 1);
  localparam int unsigned SymCtW  = (CtW0 > N) ? CtW0 : N;

  logic [SymCtW-1:0]   sym_ct_q;
  logic [ERR_CT_W-1:0] err_ct_q;
  logic                window_open;

  assign window_open = (sym_ct_q < SymCtW'(ERR_WINDOW));
  assign mask        = (enc_valid_i && window_open && (&sym_ct_q[N-1:0])) ? INJ_MASK : '0;
  assign err_ct_o    = err_ct_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sym_ct_q <= '0;
      err_ct_q <= '0;
    end else if (frame_start_i) begin
      sym_ct_q <= '0;
      err_ct_q <= '0;
    end else begin
      if (enc_valid_i && window_open) begin
        sym_ct_q <= sym_ct_q + SymCtW'(1);
      end
      if ((mask != '0) && (err_ct_q != '1)) begin
        err_ct_q <= err_ct_q + ERR_CT_W'(1);
      end
    end
  end
`else
  localparam int unsigned unused_params = N + ERR_WINDOW;
  logic unused_frame_start;

  assign unused_frame_start = frame_start_i;
  assign mask               = '0;
  assign err_ct_o           = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_en_o  <= 1'b0;
      dec_sym_o <= '0;
    end else begin
      dec_en_o  <= enc_valid_i;
      dec_sym_o <= enc_sym_i ^ mask;
    end
  end

endmodule

// File: rtl/viterbi_link_ctrl.sv
// Frame controller sequencing data, trellis tail and traceback drain for a Viterbi link.
// Optional error injection in the symbol path is enabled by VITERBI_ERR_INJ_EN.
module viterbi_link_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned FRAME_LEN  = 256,
  parameter int unsigned TAIL_BITS  = 2,
  parameter int unsigned DRAIN_LEN  = 64,
  parameter int unsigned ERR_WINDOW = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                data_i,
  output logic                enc_en_o,
  output logic                enc_bit_o,
  input  logic                enc_valid_i,
  input  logic [SYM_W-1:0]    enc_sym_i,
  output logic                dec_en_o,
  output logic [SYM_W-1:0]    dec_sym_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [ERR_CT_W-1:0] err_ct_o
);

  localparam int unsigned MaxLen0 = (FRAME_LEN > TAIL_BITS) ? FRAME_LEN : TAIL_BITS;
  localparam int unsigned MaxLen  = (MaxLen0 > DRAIN_LEN) ? MaxLen0 : DRAIN_LEN;
  localparam int unsigned CntW    = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  ctrl_state_t     state_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            enc_en_q;
  logic            frame_start;

  assign frame_start = (state_q == StIdle) && start_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      enc_en_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q  <= StData;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            enc_en_q <= 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CntW'(FRAME_LEN - 1)) begin
            state_q <= StTail;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StTail: begin
          if (cnt_q == CntW'(TAIL_BITS - 1)) begin
            state_q  <= StDrain;
            cnt_q    <= '0;
            enc_en_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDrain: begin
          if (cnt_q == CntW'(DRAIN_LEN - 1)) begin
            state_q <= StDone;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          // A start request seen here is dropped; only IDLE accepts it.
          state_q <= StIdle;
          cnt_q   <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          cnt_q    <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          enc_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign enc_en_o  = enc_en_q;
  assign enc_bit_o = (state_q == StData) && data_i;

  viterbi_err_inj #(
    .N          (N),
    .ERR_WINDOW (ERR_WINDOW)
  ) u_err_inj (
    .clk           (clk),
    .rst           (rst),
    .frame_start_i (frame_start),
    .enc_valid_i   (enc_valid_i),
    .enc_sym_i     (enc_sym_i),
    .dec_en_o      (dec_en_o),
    .dec_sym_o     (dec_sym_o),
    .err_ct_o      (err_ct_o)
  );

endmodule

// File: tb/tb_viterbi_link_ctrl.sv
// Self-checking bench for viterbi_link_ctrl: default instance plus a narrow-window instance.
// Expectations follow VITERBI_ERR_INJ_EN so the bench suits either build.
module tb_viterbi_link_ctrl;

`ifdef VITERBI_ERR_INJ_EN
  localparam bit InjOn = 1'b1;
`else
  localparam bit InjOn = 1'b0;
`endif

  localparam int FrameLen = 256;
  localparam int EncCycles = 258;
  localparam int DoneOfs = 322;
  localparam int Period = 324;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        data_i = 1'b0;
  logic        enc_valid_i = 1'b0;
  logic [1:0]  enc_sym_i = 2'b00;

  logic        enc_en_a, enc_bit_a, dec_en_a, busy_a, done_a;
  logic [1:0]  dec_sym_a;
  logic [15:0] err_ct_a;
  logic        enc_en_w, enc_bit_w, dec_en_w, busy_w, done_w;
  logic [1:0]  dec_sym_w;
  logic [15:0] err_ct_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  viterbi_link_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .data_i      (data_i),
    .enc_en_o    (enc_en_a),
    .enc_bit_o   (enc_bit_a),
    .enc_valid_i (enc_valid_i),
    .enc_sym_i   (enc_sym_i),
    .dec_en_o    (dec_en_a),
    .dec_sym_o   (dec_sym_a),
    .busy_o      (busy_a),
    .done_o      (done_a),
    .err_ct_o    (err_ct_a)
  );

  viterbi_link_ctrl #(
    .ERR_WINDOW (32)
  ) dut_w (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .data_i      (data_i),
    .enc_en_o    (enc_en_w),
    .enc_bit_o   (enc_bit_w),
    .enc_valid_i (enc_valid_i),
    .enc_sym_i   (enc_sym_i),
    .dec_en_o    (dec_en_w),
    .dec_sym_o   (dec_sym_w),
    .busy_o      (busy_w),
    .done_o      (done_w),
    .err_ct_o    (err_ct_w)
  );

  function automatic logic [1:0] exp_mask(int idx, int win);
    return (InjOn && idx < win && (idx % 16) == 15) ? 2'b01 : 2'b00;
  endfunction

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b1; data_i = 1'b1; enc_valid_i = 1'b1; enc_sym_i = 2'b11;
    repeat (2) @(negedge clk);
    checks += 8;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done_a); end
    if (enc_en_a !== 1'b0) begin failures++; $display("FAIL reset_enc_en got=%b want=0", enc_en_a); end
    if (enc_bit_a !== 1'b0) begin failures++; $display("FAIL reset_enc_bit got=%b want=0", enc_bit_a); end
    if (dec_en_a !== 1'b0) begin failures++; $display("FAIL reset_dec_en got=%b want=0", dec_en_a); end
    if (dec_sym_a !== 2'b00) begin failures++; $display("FAIL reset_dec_sym got=%b want=00", dec_sym_a); end
    if (err_ct_a !== 16'h0) begin failures++; $display("FAIL reset_err_ct got=%0d want=0", err_ct_a); end
    if (dec_sym_w !== 2'b00) begin failures++; $display("FAIL reset_dec_sym_w got=%b want=00", dec_sym_w); end
    rst = 1'b1; start_i = 1'b0; data_i = 1'b0; enc_valid_i = 1'b0; enc_sym_i = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_inject();
    logic [1:0] q_a[$];
    logic [1:0] q_w[$];
    logic [1:0] sym, exp_a, exp_w;
    int sent = 0;
    int inj_a = 0;
    int inj_w = 0;
    bit prev_valid = 1'b0;
    bit seen_done = 1'b0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    for (int c = 0; c < 400 && (sent < FrameLen || q_a.size() > 0); c++) begin
      checks += 3;
      if (dec_en_a !== prev_valid) begin
        failures++; $display("FAIL inj_dec_en cyc=%0d got=%b want=%b", c, dec_en_a, prev_valid);
      end
      if (err_ct_a !== 16'(inj_a)) begin
        failures++; $display("FAIL inj_err_ct cyc=%0d got=%0d want=%0d", c, err_ct_a, inj_a);
      end
      if (err_ct_w !== 16'(inj_w)) begin
        failures++; $display("FAIL inj_err_ct_w cyc=%0d got=%0d want=%0d", c, err_ct_w, inj_w);
      end
      if (prev_valid) begin
        exp_a = q_a.pop_front();
        exp_w = q_w.pop_front();
        checks += 2;
        if (dec_sym_a !== exp_a) begin
          failures++; $display("FAIL inj_dec_sym cyc=%0d got=%b want=%b", c, dec_sym_a, exp_a);
        end
        if (dec_sym_w !== exp_w) begin
          failures++; $display("FAIL inj_dec_sym_w cyc=%0d got=%b want=%b", c, dec_sym_w, exp_w);
        end
      end
      if (sent < FrameLen && (c % 7) != 3) begin
        sym = 2'($urandom);
        enc_valid_i = 1'b1;
        enc_sym_i = sym;
        q_a.push_back(sym ^ exp_mask(sent, 256));
        q_w.push_back(sym ^ exp_mask(sent, 32));
        if (exp_mask(sent, 256) != 2'b00) inj_a++;
        if (exp_mask(sent, 32) != 2'b00) inj_w++;
        sent++;
        prev_valid = 1'b1;
      end else begin
        enc_valid_i = 1'b0;
        prev_valid = 1'b0;
      end
      @(negedge clk);
    end
    enc_valid_i = 1'b0;
    checks += 3;
    if (sent != FrameLen || q_a.size() != 0) begin
      failures++; $display("FAIL inj_drain sent=%0d pending=%0d want=256/0", sent, q_a.size());
    end
    if (err_ct_a !== (InjOn ? 16'd16 : 16'd0)) begin
      failures++; $display("FAIL inj_total got=%0d want=%0d", err_ct_a, InjOn ? 16 : 0);
    end
    if (err_ct_w !== (InjOn ? 16'd2 : 16'd0)) begin
      failures++; $display("FAIL inj_total_w got=%0d want=%0d", err_ct_w, InjOn ? 2 : 0);
    end
    for (int c = 0; c < 400 && !seen_done; c++) begin
      @(negedge clk);
      seen_done = done_a;
    end
    repeat (3) @(negedge clk);
    checks += 2;
    if (!seen_done) begin failures++; $display("FAIL inj_done_timeout got=0 want=1"); end
    if (err_ct_a !== (InjOn ? 16'd16 : 16'd0)) begin
      failures++; $display("FAIL inj_hold_idle got=%0d want=%0d", err_ct_a, InjOn ? 16 : 0);
    end
  endtask

  task automatic test_frame_timing();
    int en_cnt = 0;
    int done_cnt = 0;
    int done_j = -1;
    int bit_bad = 0;
    logic exp_bit;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    checks += 2;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL frame_busy_rise got=%b want=1", busy_a); end
    if (err_ct_a !== 16'h0) begin failures++; $display("FAIL frame_err_clear got=%0d want=0", err_ct_a); end
    for (int j = 0; j < 330; j++) begin
      if (enc_en_a === 1'b1) en_cnt++;
      if (done_a === 1'b1) begin
        done_cnt++;
        if (done_j < 0) done_j = j;
      end
      if (j == 323) begin
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL frame_idle got=%b want=0", busy_a); end
      end
      data_i = 1'($urandom);
      #1;
      exp_bit = (j < FrameLen) ? data_i : 1'b0;
      if (enc_bit_a !== exp_bit) bit_bad++;
      @(negedge clk);
    end
    data_i = 1'b0;
    checks += 4;
    if (en_cnt != EncCycles) begin failures++; $display("FAIL frame_enc_en got=%0d want=%0d", en_cnt, EncCycles); end
    if (done_j != DoneOfs) begin failures++; $display("FAIL frame_done_at got=%0d want=%0d", done_j, DoneOfs); end
    if (done_cnt != 1) begin failures++; $display("FAIL frame_done_cnt got=%0d want=1", done_cnt); end
    if (bit_bad != 0) begin failures++; $display("FAIL frame_enc_bit bad=%0d want=0", bit_bad); end
  endtask

  task automatic test_reset_abort();
    int done_j = -1;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b0; data_i = 1'b1; enc_valid_i = 1'b1; enc_sym_i = 2'b11;
    @(negedge clk);
    checks += 6;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy_a); end
    if (enc_en_a !== 1'b0) begin failures++; $display("FAIL abort_enc_en got=%b want=0", enc_en_a); end
    if (enc_bit_a !== 1'b0) begin failures++; $display("FAIL abort_enc_bit got=%b want=0", enc_bit_a); end
    if (done_a !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", done_a); end
    if (dec_en_a !== 1'b0 || dec_sym_a !== 2'b00) begin
      failures++; $display("FAIL abort_dec got=%b/%b want=0/00", dec_en_a, dec_sym_a);
    end
    if (err_ct_a !== 16'h0) begin failures++; $display("FAIL abort_err_ct got=%0d want=0", err_ct_a); end
    rst = 1'b1; start_i = 1'b1; data_i = 1'b0; enc_valid_i = 1'b0; enc_sym_i = 2'b00;
    @(negedge clk); start_i = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL abort_first_start got=%b want=1", busy_a); end
    for (int j = 0; j < 330 && done_j < 0; j++) begin
      if (done_a === 1'b1) done_j = j;
      @(negedge clk);
    end
    checks++;
    if (done_j != DoneOfs) begin failures++; $display("FAIL abort_refill_done got=%0d want=%0d", done_j, DoneOfs); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int rises[$];
    logic prev_busy;
    int cyc = 0;
    prev_busy = busy_a;
    start_i = 1'b1;
    while (cyc < 1200 && rises.size() < 3) begin
      @(negedge clk);
      cyc++;
      if (busy_a === 1'b1 && prev_busy === 1'b0) rises.push_back(cyc);
      prev_busy = busy_a;
    end
    start_i = 1'b0;
    checks += 3;
    if (rises.size() != 3) begin
      failures++; $display("FAIL b2b_rises got=%0d want=3", rises.size());
    end else begin
      if (rises[1] - rises[0] != Period) begin
        failures++; $display("FAIL b2b_gap1 got=%0d want=%0d", rises[1] - rises[0], Period);
      end
      if (rises[2] - rises[1] != Period) begin
        failures++; $display("FAIL b2b_gap2 got=%0d want=%0d", rises[2] - rises[1], Period);
      end
    end
    repeat (330) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_inject();
    test_frame_timing();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/viterbi_link_ctrl.md
VITERBI_LINK_CTRL -- requirements
Module: viterbi_link_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4: an error is injected every 2**N valid symbols.
REQ-002 The block SHALL have parameter FRAME_LEN, default 256: number of source bits per frame.
REQ-003 The block SHALL have parameter TAIL_BITS, default 2: number of zero flush bits that terminate the trellis.
REQ-004 The block SHALL have parameter DRAIN_LEN, default 64: number of cycles allowed for decoder traceback after the tail.
REQ-005 The block SHALL have parameter ERR_WINDOW, default 256: injection is allowed only for symbol indices below this value.
REQ-006 clk  in  1  clock; the block uses one clock domain and samples on the rising edge.
REQ-007 rst  in  1  reset; synchronous, active-low.
REQ-008 start_i  in  1  frame start request.
REQ-009 data_i  in  1  source bit, consumed in cycles where enc_en_o is 1.
REQ-010 enc_en_o  out  1  encoder enable.
REQ-011 enc_bit_o  out  1  bit presented to the encoder.
REQ-012 enc_valid_i  in  1  encoder symbol valid.
REQ-013 enc_sym_i  in  2  encoder output symbol.
REQ-014 dec_en_o  out  1  decoder enable.
REQ-015 dec_sym_o  out  2  symbol to the decoder, possibly corrupted.
REQ-016 busy_o  out  1  high in every state except IDLE.
REQ-017 done_o  out  1  one-cycle pulse marking the end of a frame.
REQ-018 err_ct_o  out  16  count of injected bit flips in the current frame.

Function
REQ-019 The FSM SHALL have the states IDLE, DATA, TAIL, DRAIN and DONE.
REQ-020 IDLE -> DATA SHALL occur on the edge where start_i=1 is sampled; start_i SHALL be ignored in all other states.
REQ-021 DATA SHALL last exactly FRAME_LEN cycles, with enc_en_o=1 and enc_bit_o=data_i (combinational pass-through).
REQ-022 TAIL SHALL last exactly TAIL_BITS cycles, with enc_en_o=1 and enc_bit_o=0.
REQ-023 DRAIN SHALL last exactly DRAIN_LEN cycles, with enc_en_o=0 while the symbol path keeps forwarding.
REQ-024 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-025 If start_i=1 in DONE, the request SHALL be ignored.
REQ-026 The state length counter SHALL be sized by $clog2 of the largest length and SHALL reload to zero on every state entry.
REQ-027 The symbol path SHALL have a latency of one register stage: dec_en_o <= enc_valid_i and dec_sym_o <= enc_sym_i ^ mask.
REQ-028 sym_ct SHALL increment on each enc_valid_i=1, SHALL clear on IDLE->DATA, SHALL saturate at ERR_WINDOW, and SHALL never wrap.
REQ-029 mask SHALL be 2'b01 when enc_valid_i=1, sym_ct<ERR_WINDOW and sym_ct[N-1:0] is all ones; otherwise mask SHALL be 2'b00.
REQ-030 err_ct_o SHALL increment on each nonzero mask, SHALL saturate at 16'hFFFF, and SHALL clear on IDLE->DATA.
REQ-031 err_ct_o SHALL hold its value through DONE and IDLE.
REQ-032 enc_valid_i SHALL be honoured in every state, so late encoder symbols are still forwarded to the decoder.

Reset
REQ-033 When rst=0 at an edge, the state SHALL become IDLE and all counters SHALL clear.
REQ-034 During reset, enc_en_o, enc_bit_o, dec_en_o, dec_sym_o, busy_o, done_o and err_ct_o SHALL all be 0.
REQ-035 Reset mid-frame SHALL abort the frame with no done_o pulse.
REQ-036 After reset, the first start_i SHALL be accepted on the first edge with rst=1.

Configuration
REQ-037 With VITERBI_ERR_INJ_EN defined, the block SHALL implement the injection and counting of REQ-029 and REQ-030.
REQ-038 Without VITERBI_ERR_INJ_EN, mask SHALL be constant 2'b00, err_ct_o SHALL be tied to 0, sym_ct logic SHALL be absent, and timing SHALL be unchanged.

Structure
REQ-039 Package viterbi_ctrl_pkg SHALL hold the state enum (ctrl_state_t), the symbol width constant SYM_W=2, ERR_CT_W=16, and the mask constant INJ_MASK=2'b01.
REQ-040 Sub-module viterbi_err_inj SHALL hold sym_ct, mask generation, err_ct and the registered symbol path.
REQ-041 viterbi_err_inj SHALL be instantiated by the controller, and its body SHALL be reduced to a plain register stage when VITERBI_ERR_INJ_EN is undefined.

Verification
REQ-042 Defaults, start_i pulsed at edge k -> busy_o rises at k+1, enc_en_o is high for 258 cycles, done_o pulses in cycle k+323, then IDLE.
REQ-043 Macro on, 256 valid symbols -> flips at symbol indices 15, 31, ..., 255, with err_ct_o=16 and only dec_sym_o[0] ever flipped.
REQ-044 Macro off, same stimulus -> dec_sym_o equals enc_sym_i delayed one cycle and err_ct_o=0 throughout.
REQ-045 rst=0 asserted in DATA cycle 100 -> all outputs are 0 on the next cycle, no done_o pulse occurs, and a following start_i begins a full frame.
REQ-046 start_i held high continuously -> frames start only from IDLE, with exactly 324 cycles between consecutive busy_o rises.
REQ-047 ERR_WINDOW=32, 256 symbols -> exactly 2 injections (indices 15 and 31) and err_ct_o=2.
